// File: rtl/logic_unit.sv
// logic_unit: registered bitwise logic unit with valid/ready flow control and a saturating all-ones counter.
// Optional build macro LOGIC_UNIT_XOR_EN enables ops 100 (XOR) and 101 (XNOR); otherwise they flag err.
module logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_NAND = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Returns {err, result}; unsupported ops yield a zero result with err set.
  function automatic logic [WIDTH:0] compute(input logic [WIDTH-1:0] a_v,
                                             input logic [WIDTH-1:0] b_v,
                                             input logic [2:0]       op_v);
    logic [WIDTH-1:0] r;
    logic             e;
    r = ALL_ZERO;
    e = 1'b0;
    case (op_e'(op_v))
      OP_NAND: r = ~(a_v & b_v);
      OP_AND:  r = a_v & b_v;
      OP_OR:   r = a_v | b_v;
      OP_NOR:  r = ~(a_v | b_v);
`ifdef LOGIC_UNIT_XOR_EN
      OP_XOR:  r = a_v ^ b_v;
      OP_XNOR: r = ~(a_v ^ b_v);
`else
      OP_XOR:  begin r = ALL_ZERO; e = 1'b1; end
      OP_XNOR: begin r = ALL_ZERO; e = 1'b1; end
`endif
      OP_NOTA: r = ~a_v;
      OP_PASS: r = a_v;
      default: begin r = ALL_ZERO; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  logic [WIDTH-1:0] y_r;
  logic             err_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] ones_cnt_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             count_hit_s;
  logic [WIDTH:0]   result_s;

  assign in_ready    = !out_valid_r || out_ready;
  assign in_xfer_s   = in_valid && in_ready;
  assign out_xfer_s  = out_valid_r && out_ready;
  assign result_s    = compute(a, b, op);
  assign count_hit_s = out_xfer_s && (y_r == ALL_ONES) && !err_r;

  // Result register: load on input transfer, release on a lone output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= ALL_ZERO;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_xfer_s) begin
      y_r         <= result_s[WIDTH-1:0];
      err_r       <= result_s[WIDTH];
      out_valid_r <= 1'b1;
    end else if (out_xfer_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // All-ones counter: clear has priority over a qualifying consumption; saturates at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_r <= CNT_ZERO;
    end else if (cnt_clr) begin
      ones_cnt_r <= CNT_ZERO;
    end else if (count_hit_s && (ones_cnt_r != CNT_MAX)) begin
      ones_cnt_r <= ones_cnt_r + CNT_ONE;
    end else begin
      ones_cnt_r <= ones_cnt_r;
    end
  end

  assign y         = y_r;
  assign err       = err_r;
  assign out_valid = out_valid_r;
  assign ones_cnt  = ones_cnt_r;

endmodule
